// File: rtl/bsg_gateway_link_test_sequencer_pkg.sv
// Shared types and chip-level constants for the gateway link loopback test sequencer.
package bsg_gateway_test_pkg;

  localparam int io_ct_num_in_gp      = 1;
  localparam int gw_test_num_nodes_gp = 4*io_ct_num_in_gp + 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RUN,
    DRAIN,
    CHECK,
    DONE
  } bsg_gw_seq_state_e;

  typedef enum logic [2:0] {
    FAIL_NONE        = 3'd0,
    FAIL_NODE_ERROR  = 3'd1,
    FAIL_MISMATCH    = 3'd2,
    FAIL_NO_TRAFFIC  = 3'd3,
    FAIL_ABORTED     = 3'd4
  } bsg_gw_fail_code_e;

  // Index width that stays at least one bit for a single-node build.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_gateway_link_test_sequencer_if.sv
// Bus between the sequencer and the flattened set of loopback test nodes.
interface bsg_gateway_link_test_sequencer_if #(
  parameter int num_nodes_p   = 20,
  parameter int count_width_p = 32
);
  logic                                        node_en;
  logic [num_nodes_p-1:0]                      error;
  logic [num_nodes_p-1:0][count_width_p-1:0]   sent;
  logic [num_nodes_p-1:0][count_width_p-1:0]   received;

  modport master (output node_en, input error, input sent, input received);
  modport slave  (input node_en, output error, output sent, output received);
endinterface

// File: rtl/bsg_gateway_node_check.sv
// Selects one node and grades it: error beats mismatch beats no-traffic.
module bsg_gateway_node_check
  import bsg_gateway_test_pkg::*;
#(
  parameter int num_nodes_p   = 20,
  parameter int count_width_p = 32,
  localparam int idx_width_lp = safe_clog2(num_nodes_p)
) (
  input  logic [idx_width_lp-1:0]                  idx_i,
  input  logic [num_nodes_p-1:0]                   error_i,
  input  logic [num_nodes_p-1:0][count_width_p-1:0] sent_i,
  input  logic [num_nodes_p-1:0][count_width_p-1:0] received_i,
  output bsg_gw_fail_code_e                        fail_code_o,
  output logic [count_width_p-1:0]                 sent_o,
  output logic [count_width_p-1:0]                 received_o
);

  logic [num_nodes_p-1:0][2:0] node_code;

  generate
    for (genvar gi = 0; gi < num_nodes_p; gi++) begin : g_node
      assign node_code[gi] = error_i[gi]                   ? FAIL_NODE_ERROR :
                             (sent_i[gi] != received_i[gi]) ? FAIL_MISMATCH   :
                             (sent_i[gi] == '0)             ? FAIL_NO_TRAFFIC :
                                                              FAIL_NONE;
    end
  endgenerate

  always_comb begin
    fail_code_o = FAIL_NONE;
    sent_o      = '0;
    received_o  = '0;
    for (int k = 0; k < num_nodes_p; k++) begin
      if (idx_i == idx_width_lp'(k)) begin
        fail_code_o = bsg_gw_fail_code_e'(node_code[k]);
        sent_o      = sent_i[k];
        received_o  = received_i[k];
      end
    end
  end

endmodule

// File: rtl/bsg_gateway_link_test_sequencer.sv
// Settles, runs and drains every loopback node, then scans each node once and latches pass/fail.
module bsg_gateway_link_test_sequencer
  import bsg_gateway_test_pkg::*;
#(
  parameter int num_nodes_p     = 20,
  parameter int count_width_p   = 32,
  parameter int settle_cycles_p = 64,
  parameter int run_cycles_p    = 5000,
  parameter int drain_cycles_p  = 500,
  parameter int timer_width_p   = 32,
  localparam int idx_width_lp   = safe_clog2(num_nodes_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  bsg_gateway_link_test_sequencer_if.master nodes,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [idx_width_lp-1:0]   fail_idx_o,
  output logic [2:0]                fail_code_o,
  output logic [count_width_p-1:0]  fail_sent_o,
  output logic [count_width_p-1:0]  fail_received_o,
  output logic [timer_width_p-1:0]  enabled_cycles_o
);

  localparam logic [timer_width_p-1:0] settle_last_lp = timer_width_p'(settle_cycles_p - 1);
  localparam logic [timer_width_p-1:0] run_last_lp    = timer_width_p'(run_cycles_p - 1);
  localparam logic [timer_width_p-1:0] drain_last_lp  = timer_width_p'(drain_cycles_p - 1);
  localparam logic [idx_width_lp-1:0]  idx_last_lp    = idx_width_lp'(num_nodes_p - 1);

  bsg_gw_seq_state_e state_reg, state_next;
  logic [timer_width_p-1:0] timer_reg, timer_next;
  logic [idx_width_lp-1:0]  idx_reg, idx_next;
  logic                     aborted_reg, aborted_next;

  logic node_en_reg, node_en_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic pass_reg, pass_next;
  logic [idx_width_lp-1:0]  fail_idx_reg, fail_idx_next;
  bsg_gw_fail_code_e        fail_code_reg, fail_code_next;
  logic [count_width_p-1:0] fail_sent_reg, fail_sent_next;
  logic [count_width_p-1:0] fail_received_reg, fail_received_next;
  logic [timer_width_p-1:0] enabled_reg, enabled_next;

  bsg_gw_fail_code_e        check_code;
  logic [count_width_p-1:0] check_sent, check_received;

  bsg_gateway_node_check #(
    .num_nodes_p  (num_nodes_p),
    .count_width_p(count_width_p)
  ) u_node_check (
    .idx_i      (idx_reg),
    .error_i    (nodes.error),
    .sent_i     (nodes.sent),
    .received_i (nodes.received),
    .fail_code_o(check_code),
    .sent_o     (check_sent),
    .received_o (check_received)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      idx_reg           <= '0;
      aborted_reg       <= 1'b0;
      node_en_reg       <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      pass_reg          <= 1'b0;
      fail_idx_reg      <= '0;
      fail_code_reg     <= FAIL_NONE;
      fail_sent_reg     <= '0;
      fail_received_reg <= '0;
      enabled_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      idx_reg           <= idx_next;
      aborted_reg       <= aborted_next;
      node_en_reg       <= node_en_next;
      busy_reg          <= busy_next;
      done_reg          <= done_next;
      pass_reg          <= pass_next;
      fail_idx_reg      <= fail_idx_next;
      fail_code_reg     <= fail_code_next;
      fail_sent_reg     <= fail_sent_next;
      fail_received_reg <= fail_received_next;
      enabled_reg       <= enabled_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    idx_next     = idx_reg;
    aborted_next = aborted_reg;
    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = SETTLE;
          timer_next = '0;
        end
      end
      SETTLE, RUN: begin
        if (abort_i) begin
          state_next   = DRAIN;
          timer_next   = '0;
          aborted_next = 1'b1;
        end else if (timer_reg == ((state_reg == SETTLE) ? settle_last_lp : run_last_lp)) begin
          state_next = (state_reg == SETTLE) ? RUN : DRAIN;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + timer_width_p'(1);
        end
      end
      DRAIN: begin
        if (timer_reg == drain_last_lp) begin
          state_next = CHECK;
          idx_next   = '0;
        end else begin
          timer_next = timer_reg + timer_width_p'(1);
        end
      end
      CHECK: begin
        if (check_code != FAIL_NONE || idx_reg == idx_last_lp) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + idx_width_lp'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs are computed from the upcoming state so that every one of them is a flop.
  always_comb begin
    node_en_next       = (state_next == RUN);
    busy_next          = (state_next != IDLE) && (state_next != DONE);
    done_next          = (state_next == DONE);
    pass_next          = pass_reg;
    fail_idx_next      = fail_idx_reg;
    fail_code_next     = fail_code_reg;
    fail_sent_next     = fail_sent_reg;
    fail_received_next = fail_received_reg;
    enabled_next       = enabled_reg;
    if (state_reg == RUN) begin
      enabled_next = enabled_reg + timer_width_p'(1);
    end
    if (state_reg == CHECK) begin
      if (check_code != FAIL_NONE) begin
        pass_next          = 1'b0;
        fail_idx_next      = idx_reg;
        fail_code_next     = check_code;
        fail_sent_next     = check_sent;
        fail_received_next = check_received;
      end else if (idx_reg == idx_last_lp) begin
        pass_next      = !aborted_reg;
        fail_idx_next  = '0;
        fail_code_next = aborted_reg ? FAIL_ABORTED : FAIL_NONE;
      end
    end
  end

  assign nodes.node_en    = node_en_reg;
  assign busy_o           = busy_reg;
  assign done_o           = done_reg;
  assign pass_o           = pass_reg;
  assign fail_idx_o       = fail_idx_reg;
  assign fail_code_o      = fail_code_reg;
  assign fail_sent_o      = fail_sent_reg;
  assign fail_received_o  = fail_received_reg;
  assign enabled_cycles_o = enabled_reg;

endmodule
